// File: rtl/rx_iq_intf.sv
// rx_iq_intf: RX-side I/Q interface. Applies a signed gain with saturation to ADC
// samples, buffers them in a first-word-fall-through FIFO, and streams them to the
// RX core once a prefill level is reached, using a valid/ready handshake.
// Ports: clk/rstn (sync, active-low); adc_iq_pack_i/adc_iq_valid_i in; rx_gain_i,
// rx_start_threshold_i config; rx_i_o/rx_q_o/rx_iq_valid_o/rx_iq_ready_i out;
// rx_iq_fifo_empty_o, data_count_o, overflow_cnt_o status.
// Latency: 2 cycles input to FIFO-visible (3 with RX_IQ_INTF_DC_REMOVAL_EN defined,
// which adds a per-channel IIR DC estimator ahead of the gain stage).
// Backpressure: ready may stay low indefinitely; writes into a full FIFO are dropped
// and counted, unless a pop happens in the same cycle.
module rx_iq_intf #(
    parameter int IQ_DATA_WIDTH   = 16,
    parameter int FIFO_ADDR_WIDTH = 9,
    parameter int GAIN_SHIFT      = 7,
    parameter int DC_SHIFT        = 6
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [2*IQ_DATA_WIDTH-1:0]        adc_iq_pack_i,
    input  logic                              adc_iq_valid_i,
    input  logic signed [9:0]                 rx_gain_i,
    input  logic [FIFO_ADDR_WIDTH:0]          rx_start_threshold_i,
    output logic signed [IQ_DATA_WIDTH-1:0]   rx_i_o,
    output logic signed [IQ_DATA_WIDTH-1:0]   rx_q_o,
    output logic                              rx_iq_valid_o,
    input  logic                              rx_iq_ready_i,
    output logic                              rx_iq_fifo_empty_o,
    output logic [FIFO_ADDR_WIDTH:0]          data_count_o,
    output logic [15:0]                       overflow_cnt_o
);
    localparam int IQ = IQ_DATA_WIDTH;
    localparam int PW = IQ_DATA_WIDTH + 10;
    localparam int AW = FIFO_ADDR_WIDTH;
    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 <<< (IQ - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    function automatic logic signed [IQ-1:0] sat_iq(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[IQ-1:0];
        else if (v < SAT_MIN) return SAT_MIN[IQ-1:0];
        else                  return v[IQ-1:0];
    endfunction

    logic signed [IQ-1:0] x_i, x_q;
    assign x_i = adc_iq_pack_i[IQ-1:0];
    assign x_q = adc_iq_pack_i[2*IQ-1:IQ];

    // Samples presented to the gain stage
    logic signed [IQ-1:0] g_in_i, g_in_q;
    logic                 g_in_vld;

`ifdef RX_IQ_INTF_DC_REMOVAL_EN
    // Estimator kept scaled by 2^DC_SHIFT so the slow IIR keeps its fractional bits.
    localparam int DW = IQ_DATA_WIDTH + DC_SHIFT;

    function automatic logic signed [DW-1:0] dc_upd(input logic signed [DW-1:0] acc,
                                                    input logic signed [IQ-1:0] x);
        logic signed [DW:0] diff;
        diff = ((DW+1)'(x) <<< DC_SHIFT) - (DW+1)'(acc);
        return acc + DW'(diff >>> DC_SHIFT);
    endfunction

    logic signed [DW-1:0] dci_q, dcq_q;
    logic signed [IQ-1:0] dc_i, dc_q;
    logic signed [IQ-1:0] s1_i_q, s1_q_q;
    logic                 s1_vld_q;

    assign dc_i = IQ'(dci_q >>> DC_SHIFT);
    assign dc_q = IQ'(dcq_q >>> DC_SHIFT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dci_q    <= '0;
            dcq_q    <= '0;
            s1_i_q   <= '0;
            s1_q_q   <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= adc_iq_valid_i;
            if (adc_iq_valid_i) begin
                dci_q  <= dc_upd(dci_q, x_i);
                dcq_q  <= dc_upd(dcq_q, x_q);
                s1_i_q <= sat_iq(PW'(x_i) - PW'(dc_i));
                s1_q_q <= sat_iq(PW'(x_q) - PW'(dc_q));
            end
        end
    end

    assign g_in_i   = s1_i_q;
    assign g_in_q   = s1_q_q;
    assign g_in_vld = s1_vld_q;
`else
    assign g_in_i   = x_i;
    assign g_in_q   = x_q;
    assign g_in_vld = adc_iq_valid_i;
`endif

    // Gain stage: multiply, arithmetic shift, saturate; write strobe travels alongside.
    logic signed [PW-1:0] prod_i, prod_q;
    logic signed [IQ-1:0] gi_q, gq_q;
    logic                 wr_q;

    assign prod_i = PW'(g_in_i) * PW'(rx_gain_i);
    assign prod_q = PW'(g_in_q) * PW'(rx_gain_i);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gi_q <= '0;
            gq_q <= '0;
            wr_q <= 1'b0;
        end else begin
            gi_q <= sat_iq(prod_i >>> GAIN_SHIFT);
            gq_q <= sat_iq(prod_q >>> GAIN_SHIFT);
            wr_q <= g_in_vld;
        end
    end

    // FIFO
    logic [2*IQ-1:0] mem_q [2**AW];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     ovf_q;
    logic            empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH);
    assign pop   = rx_iq_valid_o & rx_iq_ready_i;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push  = wr_q & (~full | pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {gq_q, gi_q};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (wr_q && !push && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
        end
    end

    // Prefill FSM
    typedef enum logic {FILL, STREAM} state_t;
    state_t      state_q, state_d;
    logic [AW:0] thr;

    assign thr = (rx_start_threshold_i > DEPTH) ? DEPTH : rx_start_threshold_i;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        rx_iq_valid_o = 1'b0;
        case (state_q)
            FILL: begin
                if (count_q >= thr && !empty) state_d = STREAM;
            end
            STREAM: begin
                rx_iq_valid_o = ~empty;
                // Underflow only if nothing is about to land this cycle.
                if (empty && !wr_q) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    assign rx_i_o             = empty ? '0 : mem_q[rd_ptr_q][IQ-1:0];
    assign rx_q_o             = empty ? '0 : mem_q[rd_ptr_q][2*IQ-1:IQ];
    assign rx_iq_fifo_empty_o = empty;
    assign data_count_o       = count_q;
    assign overflow_cnt_o     = ovf_q;

endmodule

// File: tb/tb_rx_iq_intf.sv
// Bench for rx_iq_intf: scoreboard of expected {q,i} pushed at stimulus time and
// popped on each accepted output handshake; directed checks for status outputs.
module tb_rx_iq_intf;
    logic               clk = 1'b0;
    logic               rstn;
    logic [31:0]        adc_iq_pack;
    logic               adc_iq_valid;
    logic signed [9:0]  rx_gain;
    logic [9:0]         rx_start_threshold;
    logic signed [15:0] rx_i, rx_q;
    logic               rx_iq_valid;
    logic               rx_iq_ready;
    logic               rx_iq_fifo_empty;
    logic [9:0]         data_count;
    logic [15:0]        overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];
    bit          sb_en = 1'b1;
    bit          stab_en = 1'b0;
    bit          hold_pend = 1'b0;
    logic signed [15:0] held_i, held_q;
    logic signed [15:0] last_i = '0;

    always #5 clk = ~clk;

    rx_iq_intf dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .adc_iq_pack_i        (adc_iq_pack),
        .adc_iq_valid_i       (adc_iq_valid),
        .rx_gain_i            (rx_gain),
        .rx_start_threshold_i (rx_start_threshold),
        .rx_i_o               (rx_i),
        .rx_q_o               (rx_q),
        .rx_iq_valid_o        (rx_iq_valid),
        .rx_iq_ready_i        (rx_iq_ready),
        .rx_iq_fifo_empty_o   (rx_iq_fifo_empty),
        .data_count_o         (data_count),
        .overflow_cnt_o       (overflow_cnt)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample per call; consecutive calls give back-to-back samples.
    task automatic push(input logic signed [15:0] i, input logic signed [15:0] q,
                        input logic signed [15:0] ei, input logic signed [15:0] eq,
                        input bit keep);
        @(posedge clk); #1;
        adc_iq_pack  = {q, i};
        adc_iq_valid = 1'b1;
        if (keep) sb.push_back({eq, ei});
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        adc_iq_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: compare every accepted sample against the scoreboard.
    always @(negedge clk) begin
        if (rstn && rx_iq_valid && rx_iq_ready) begin
            if (sb_en) begin
                if (sb.size() == 0) begin
                    check("sb_extra_output", 1, 0);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    check("sb_i", rx_i, $signed(e[15:0]));
                    check("sb_q", rx_q, $signed(e[31:16]));
                end
            end else begin
                last_i <= rx_i;
            end
        end
    end

    // Output must hold while valid is stalled by ready.
    always @(negedge clk) begin
        if (stab_en && hold_pend) begin
            check("bp_valid_hold", rx_iq_valid, 1);
            check("bp_i_hold", rx_i, held_i);
            check("bp_q_hold", rx_q, held_q);
        end
        hold_pend <= stab_en && rx_iq_valid && !rx_iq_ready;
        held_i    <= rx_i;
        held_q    <= rx_q;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; adc_iq_pack = '0; adc_iq_valid = 1'b0;
        rx_gain = 10'sd128; rx_start_threshold = 10'd4; rx_iq_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rx_iq_valid, 0);
        check("rst_empty", rx_iq_fifo_empty, 1);
        check("rst_count", data_count, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_i", rx_i, 0);
        check("rst_q", rx_q, 0);
        @(posedge clk); #1 rstn = 1'b1;

`ifndef RX_IQ_INTF_DC_REMOVAL_EN
        // Unity gain, prefill of 4
        fork
            begin
                int n = 0;
                @(negedge clk);
                while (!rx_iq_valid && n < 50) begin @(negedge clk); n++; end
                check("unity_valid_rise", rx_iq_valid, 1);
                check("unity_thr_reached", data_count >= 4, 1);
            end
            begin
                for (int k = 0; k < 8; k++) push(100, -100, 100, -100, 1'b1);
                idle(0);
            end
        join
        wait_drain("unity_drain", 100);

        // Saturation and shift rounding
        rx_start_threshold = 10'd0;
        rx_gain = 10'sd511;
        push(32767, -32768, 32767, -32768, 1'b1);
        idle(1);
        rx_gain = -10'sd512;
        push(-32768, 100, 32767, -400, 1'b1);
        idle(1);
        rx_gain = 10'sd64;
        push(7, -7, 3, -4, 1'b1);
        idle(1);
        wait_drain("sat_drain", 50);

        // Overflow: 520 in, 512 kept
        rx_gain = 10'sd128;
        rx_iq_ready = 1'b0;
        for (int k = 0; k < 520; k++) push(16'(k), 16'(-k), 16'(k), 16'(-k), k < 512);
        idle(3);
        check("ovf_count", data_count, 512);
        check("ovf_cnt", overflow_cnt, 8);
        check("ovf_not_empty", rx_iq_fifo_empty, 0);
        rx_iq_ready = 1'b1;
        wait_drain("ovf_drain", 700);
        check("ovf_empty_after", rx_iq_fifo_empty, 1);

        // Underflow and refill to threshold 16
        rx_start_threshold = 10'd16;
        for (int k = 0; k < 16; k++) push(16'(200 + k), 16'(-k), 16'(200 + k), 16'(-k), 1'b1);
        idle(0);
        wait_drain("uf_drain1", 100);
        @(negedge clk);
        check("uf_idle_valid", rx_iq_valid, 0);
        for (int k = 0; k < 15; k++) push(16'(300 + k), 16'(k), 16'(300 + k), 16'(k), 1'b1);
        idle(5);
        @(negedge clk);
        check("uf_fill_valid", rx_iq_valid, 0);
        check("uf_fill_count", data_count, 15);
        push(315, 15, 315, 15, 1'b1);
        idle(0);
        wait_drain("uf_drain2", 100);

        // Back-pressure with ready toggling every cycle
        rx_start_threshold = 10'd0;
        stab_en = 1'b1;
        fork
            repeat (80) begin @(posedge clk); #1 rx_iq_ready = ~rx_iq_ready; end
            begin
                for (int k = 0; k < 20; k++) push(16'(-500 - k), 16'(k * 3), 16'(-500 - k), 16'(k * 3), 1'b1);
                idle(0);
            end
        join
        stab_en = 1'b0;
        rx_iq_ready = 1'b1;
        wait_drain("bp_drain", 100);

        // Overflow counter accumulates across drains until reset
        check("ovf_cnt_kept", overflow_cnt, 8);
`endif

        // Reset mid-stream, with one sample still in the gain stage
        rx_iq_ready = 1'b0;
        rx_start_threshold = 10'd0;
        rx_gain = 10'sd128;
        for (int k = 0; k < 5; k++) push(16'(k), 16'(k), 16'(k), 16'(k), 1'b1);
        idle(3);
        check("mid_count", data_count, 5);
        push(77, 77, 77, 77, 1'b0);
        @(posedge clk); #1;
        adc_iq_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", rx_iq_valid, 0);
        check("mid_rst_count", data_count, 0);
        check("mid_rst_ovf", overflow_cnt, 0);
        sb.delete();
        @(posedge clk); #1 rstn = 1'b1;
        rx_iq_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_inflight_dropped", data_count, 0);
        check("mid_empty", rx_iq_fifo_empty, 1);

        // Constant input of 1000
`ifdef RX_IQ_INTF_DC_REMOVAL_EN
        sb_en = 1'b0;
        for (int k = 0; k < 2000; k++) push(1000, 0, 0, 0, 1'b0);
        idle(6);
        check("dc_residual_small", (last_i < 20 && last_i > -20), 1);
`else
        for (int k = 0; k < 2000; k++) push(1000, 0, 1000, 0, 1'b1);
        idle(0);
        wait_drain("dc_off_drain", 100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_iq_intf.md
Name: rx_iq_intf

Overview:
- Receive-side counterpart of the TX I/Q interface.
- Accepts packed I/Q samples from the RF/ADC side, applies a signed baseband gain with saturation, and buffers them in an internal FIFO.
- Releases samples to the RX core only after a programmable prefill level is reached, using a valid/ready handshake.
- Reports FIFO empty and counts dropped (overflow) samples.

Parameters:
- IQ_DATA_WIDTH, 16, width of each I and Q sample.
- FIFO_ADDR_WIDTH, 9, FIFO depth = 2**FIFO_ADDR_WIDTH (512).
- GAIN_SHIFT, 7, right shift applied after the gain multiply (rx_gain 128 = unity).
- DC_SHIFT, 6, IIR time constant for the optional DC removal.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- adc_iq_pack  in  2*IQ_DATA_WIDTH  {q, i}; q in upper half, i in lower half; both signed.
- adc_iq_valid  in  1  sample strobe from RF side.
- rx_gain  in  10  signed gain.
- rx_start_threshold  in  FIFO_ADDR_WIDTH+1  prefill level required before streaming.
- rx_i  out  IQ_DATA_WIDTH  signed I to RX core.
- rx_q  out  IQ_DATA_WIDTH  signed Q to RX core.
- rx_iq_valid  out  1  output sample valid.
- rx_iq_ready  in  1  RX core accepts sample.
- rx_iq_fifo_empty  out  1  FIFO empty.
- data_count  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy.
- overflow_cnt  out  16  dropped-sample counter.

Behaviour:
- Reset values: rx_i = 0, rx_q = 0, rx_iq_valid = 0, rx_iq_fifo_empty = 1, data_count = 0, overflow_cnt = 0, state = FILL. The gain pipeline and FIFO pointers are also cleared.
- Gain stage, 1 register cycle:
  - prod = sample * rx_gain (IQ+10 bits, signed).
  - res = prod >>> GAIN_SHIFT, arithmetic.
  - Saturate res to [-2^(IQ-1), 2^(IQ-1)-1].
  - Write enable is registered alongside: wr = adc_iq_valid delayed 1 cycle.
  - Input-to-FIFO-visible latency is 2 cycles: gain register, then FIFO write.
- FIFO:
  - First-word-fall-through; rx_i/rx_q always show the head entry, 0 when empty.
  - Write when full is dropped and overflow_cnt increments. Exception: a pop occurs in the same cycle, in which case the write is accepted.
  - Simultaneous push and pop on a non-empty FIFO leaves data_count unchanged.
  - overflow_cnt saturates at 16'hFFFF and is cleared only by reset.
- State machine:
  - FILL: rx_iq_valid = 0, no pops. Go to STREAM when data_count >= rx_start_threshold and data_count != 0. A threshold of 0 therefore means "stream when non-empty".
  - STREAM: rx_iq_valid = ~rx_iq_fifo_empty. Pop when rx_iq_valid & rx_iq_ready. Return to FILL when the FIFO is empty and no write lands that cycle (underflow).
  - A threshold greater than depth is clamped to depth.
  - rx_iq_ready may be held low indefinitely. rx_i, rx_q and rx_iq_valid stay stable while valid & ~ready.
- Reset mid-stream: FIFO contents are discarded and the block returns to FILL on the next edge. In-flight gain-stage samples are discarded.

Optional Feature:
- Macro: RX_IQ_INTF_DC_REMOVAL_EN.
- Defined:
  - Before the gain stage, each of I and Q passes through dc += (x - dc) >>> DC_SHIFT, updated only on adc_iq_valid. dc uses IQ+DC_SHIFT fractional-extended bits.
  - The stage outputs x - dc, saturated to IQ bits.
  - This adds 1 cycle of latency (total 3). The estimator resets to 0.
- Undefined: no DC stage; total latency 2; results are bit-exact gain-only.

Test Plan:
- Unity gain with rx_gain=128, threshold=4, ready=1: push i=100,q=-100 ×8.
  - rx_iq_valid rises only after count hits 4.
  - Outputs are exactly 100/-100, in order, with none lost.
- Saturation with rx_gain=511: input i=32767, q=-32768 -> rx_i=32767, rx_q=-32768.
- Saturation with rx_gain=-512: input i=-32768 -> rx_i=32767.
- Overflow with ready=0, threshold=0: push 520 samples -> data_count=512 and overflow_cnt=8. Then with ready=1, the first 512 samples drain in order.
- Underflow with threshold=16, ready=1: burst 16 samples, then stop. Streaming emits 16 samples, returns to FILL, and rx_iq_valid stays 0 until 16 more samples arrive.
- Back-pressure and reset: toggle ready every cycle -> each sample is seen exactly once and output is stable while ~ready. Assert rstn=0 mid-stream -> next cycle valid=0, count=0, overflow_cnt=0.
- DC removal with RX_IQ_INTF_DC_REMOVAL_EN defined: constant input i=1000 for 2000 samples -> |rx_i| < 20 at the end.
- DC removal with the macro undefined: same stimulus -> rx_i=1000 throughout.
